// File: rtl/wand_arb_tx.sv
// wand_arb_tx: bit-serial wired-AND transmitter with bitwise arbitration.
// Lowest frame value wins; losers go recessive and keep listening.
module wand_arb_tx #(
  parameter int WIDTH = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic             bus_in,
  output logic             drive,
  output logic             busy,
  output logic             done,
  output logic             won,
  output logic             err,
  output logic [WIDTH-1:0] rx_data
);
  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic IDLE = 1'b0;
  localparam logic SEND = 1'b1;
  logic             state;
  logic [WIDTH-1:0] sh;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic             arb;
  logic             fault;
  logic             lose;
  logic             last_cyc;
  assign busy = state;
  // an unknown net reads as a fault, as does a dominant bit read back recessive
  assign fault    = (bus_in !== 1'b0 && bus_in !== 1'b1) || (!drive && bus_in === 1'b1);
  assign lose     = arb && drive && !bus_in;
  assign last_cyc = cnt == CW'(BIT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      drive   <= 1'b1;
      done    <= 1'b0;
      won     <= 1'b0;
      err     <= 1'b0;
      rx_data <= '0;
      sh      <= '0;
      idx     <= '0;
      cnt     <= '0;
      arb     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state   <= SEND;
          sh      <= data;
          arb     <= 1'b1;
          idx     <= IW'(WIDTH - 1);
          cnt     <= '0;
          won     <= 1'b0;
          rx_data <= '0;
          drive   <= data[WIDTH-1];
        end
      end else if (!last_cyc) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt     <= '0;
        rx_data <= {rx_data[WIDTH-2:0], bus_in};
        if (fault) begin
          state <= IDLE;
          err   <= 1'b1;
          drive <= 1'b1;
        end else if (idx == '0) begin
          state <= IDLE;
          done  <= 1'b1;
          won   <= arb && !lose;
          drive <= 1'b1;
        end else begin
          idx   <= idx - 1'b1;
          arb   <= arb && !lose;
          drive <= (arb && !lose) ? sh[idx-1'b1] : 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/wand_arb_tx.md
# wand_arb_tx

Bit-serial transmitter for a shared wired-AND (`wand`) net, with bitwise arbitration. It drives a frame onto the net MSB-first and reads the resolved net value back on every bit. If it is outvoted, it goes recessive and keeps listening. Several instances share one `wand` net; the instance sending the numerically lowest frame wins without corrupting it. This is the driver side of the net-resolution behaviour our continuous-assignment examples exercise.

## Interface

- `WIDTH`, 8: frame length in bits (≥ 2).
- `BIT_CYCLES`, 4: clock cycles per bit (≥ 2).

- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to send `data`; sampled only while idle.
- `data`  in  `WIDTH`  frame to send; captured on accepted `start`.
- `bus_in`  in  1  resolved value of the shared `wand` net.
- `drive`  out  1  value this instance drives onto the net; 1 = recessive.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse: frame completed, `won` and `rx_data` valid.
- `won`  out  1  1 = this instance never lost arbitration in the last frame.
- `err`  out  1  one-cycle pulse: bus fault, frame aborted.
- `rx_data`  out  `WIDTH`  frame as resolved on the net.

## Operation

- States:
  - IDLE: `drive`=1, `busy`=0.
  - SEND: `busy`=1. Contains a bit index (`WIDTH-1` down to 0), a cycle counter (0..`BIT_CYCLES-1`) and an `arb` flag (1 = still contending).
- IDLE→SEND on `start`=1:
  - Latch `data`.
  - `arb`=1, bit index = `WIDTH-1`, cycle counter = 0.
  - Clear `won` and `rx_data`.
- In SEND, `drive` = current data bit if `arb`=1, else 1.
- Sampling happens on the last cycle of each bit (counter = `BIT_CYCLES-1`). The sampled `bus_in` is shifted into the LSB of `rx_data`.
- Sample classification:
  - `bus_in` is X or Z (compare with `===`): bus fault.
  - `drive`=0 and `bus_in`=1: bus fault.
  - `drive`=1, `arb`=1, `bus_in`=0: arbitration lost. Set `arb`=0. The frame continues in listen-only mode.
  - Any other combination: normal.
- Bus fault:
  - Pulse `err`, go to IDLE. `drive`=1 the next cycle.
  - `rx_data` holds the bits received so far; `won` stays 0.
- After bit 0 is sampled without a fault:
  - Pulse `done`, set `won`=`arb`, return to IDLE.
- `start` while `busy`=1 is ignored; `data` changes during SEND have no effect.
- `start` is accepted in the same cycle that `done` or `err` is high, because `busy`=0 in that cycle.
- Reset mid-frame: all outputs return immediately to their reset values. The net is released and no `done` or `err` pulse is produced.

## Timing

- Reset values: `drive`=1, `busy`=0, `done`=0, `won`=0, `err`=0, `rx_data`=0, state IDLE.
- Let `start` be accepted at edge T, and let B = `BIT_CYCLES`.
- From cycle T+1: `busy`=1 and `drive` = `data[WIDTH-1]`.
- Bit k (k=0 is the MSB) occupies cycles T+1+kB through T+(k+1)B. It is sampled at cycle T+(k+1)B.
- `done` goes high at cycle T+1+`WIDTH`·B. In the same cycle `busy`=0 and `drive`=1.
- Arbitration loss sampled at cycle S: `drive`=1 from cycle S+1 to the end of the frame. `busy` and timing are unchanged.
- Fault sampled at cycle S: `err`=1, `busy`=0 and `drive`=1 at cycle S+1.
- `won` and `rx_data` hold their values until the next accepted `start`.
- All outputs are registered; there is no combinational path from `bus_in` to `drive`.

## Test plan

All scenarios use `WIDTH`=8 and `BIT_CYCLES`=4.

- Solo send, loopback: `bus_in`=`drive`, `start` with `data`=0xA5 at T → `busy` high T+1..T+32, `done` at T+33, `won`=1, `rx_data`=0xA5.
- Two instances on one `wand` net, A sends 0xA5 and B sends 0xA3, both started at T:
  - A loses at bit 2 (sampled at T+24) and drives 1 from T+25.
  - Both assert `done` at T+33.
  - A: `won`=0. B: `won`=1. Both: `rx_data`=0xA3.
- Fault on X: `bus_in`=1'bx at the first sample (T+4) → `err` at T+5, `busy`=0, `drive`=1, `done` never asserted.
- Dominant mismatch: `drive`=0 while `bus_in` is forced to 1 at a sample → `err` on the next cycle and the frame is aborted.
- Overlap handling:
  - `start` pulsed with 0x00 at T+10 during a frame → ignored; the original frame completes unchanged.
  - `start` pulsed in the `done` cycle → accepted, `busy` high on the next cycle.
- Reset mid-frame: `rst_n` low at T+12 while `drive`=0 → `drive`=1 and `busy`=0 immediately, with no `done` or `err`. After release, a new frame runs normally.
